nvme_fifo_pack: RTL and testbench



---
 rtl/nvme_fifo_pack_pkg.sv | 11 +
 rtl/nvme_beat_reg.sv | 31 +++
 rtl/nvme_fifo_pack.sv | 73 +++++++
 tb/tb_nvme_fifo_pack.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/nvme_fifo_pack_pkg.sv
// nvme_fifo_pack_pkg: shared constants and the clog2 helper for the wide packing blocks.
package nvme_fifo_pack_pkg;
    localparam logic zero = 1'b0;
    localparam logic one = 1'b1;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int n = 1; n < v; n = n << 1) r++;
        return r;
    endfunction
endpackage

// File: rtl/nvme_beat_reg.sv
// nvme_beat_reg: valid/ready output register; loads only when free, holds its payload until taken.
module nvme_beat_reg #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [width-1:0] i_data,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [width-1:0] o_data,
    output logic             o_free
);
    import nvme_fifo_pack_pkg::*;
    logic             r_valid;
    logic [width-1:0] r_data;
    assign o_free  = ~r_valid | i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= zero;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= one;
            r_data  <= i_data;
        end else if (i_ready) begin
            r_valid <= zero;
        end
    end
endmodule

// File: rtl/nvme_fifo_pack.sv
// nvme_fifo_pack: packs ratio narrow FIFO words into one wide beat with word mask, last and err.
module nvme_fifo_pack
    import nvme_fifo_pack_pkg::*;
#(
    parameter int in_width  = 32,
    parameter int ratio     = 4,
    parameter int ratio_log = clog2(ratio)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_val,
    input  logic [in_width-1:0]       i_data,
    input  logic                      i_last,
    input  logic                      i_err,
    output logic                      i_ack,
    output logic                      o_valid,
    output logic [in_width*ratio-1:0] o_data,
    output logic [ratio-1:0]          o_wmask,
    output logic                      o_last,
    output logic                      o_err,
    input  logic                      o_ready
);
    localparam int beat_w = in_width*ratio + ratio + 2;
    localparam logic [0:0] fill = 1'b0;
    localparam logic [0:0] hold = 1'b1;
    logic [0:0]                r_state;
    logic [in_width*ratio-1:0] r_data, w_data;
    logic [ratio-1:0]          r_mask, w_mask;
    logic                      r_last, r_err, w_last, w_err;
    logic [ratio_log-1:0]      r_idx;
    logic                      w_complete, w_free, w_load;
    logic [beat_w-1:0]         w_beat;
    assign i_ack = i_val & (r_state == fill);
    // w_* is the assembly as it stands after this cycle's word; in HOLD it equals the held beat.
    always_comb begin
        w_data = r_data;
        for (int k = 0; k < ratio; k++)
            if (i_ack && r_idx == ratio_log'(k)) w_data[k*in_width +: in_width] = i_data;
        w_mask = r_mask | (ratio'(i_ack) << r_idx);
        w_last = i_ack ? i_last : r_last;
        w_err  = r_err | (i_ack & i_err);
    end
    assign w_complete = i_ack & (i_last | (r_idx == ratio_log'(ratio - 1)));
    assign w_load     = (w_complete | (r_state == hold)) & w_free;
    always_ff @(posedge clk) begin
        if (reset || w_load) begin
            r_state <= fill;
            r_data  <= '0;
            r_mask  <= '0;
            r_last  <= zero;
            r_err   <= zero;
            r_idx   <= '0;
        end else if (i_ack) begin
            r_state <= w_complete ? hold : fill;
            r_data  <= w_data;
            r_mask  <= w_mask;
            r_last  <= w_last;
            r_err   <= w_err;
            r_idx   <= w_complete ? '0 : r_idx + 1'b1;
        end
    end
    nvme_beat_reg #(.width(beat_w)) u_out (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load),
        .i_data  ({w_data, w_mask, w_last, w_err}),
        .i_ready (o_ready),
        .o_valid (o_valid),
        .o_data  (w_beat),
        .o_free  (w_free)
    );
    assign {o_data, o_wmask, o_last, o_err} = w_beat;
endmodule

// File: tb/tb_nvme_fifo_pack.sv
// tb_nvme_fifo_pack: directed and random stimulus against a queue-based model of the packer.
module tb_nvme_fifo_pack;
    logic         clk = 0, reset = 1, i_val = 0, i_last = 0, i_err = 0, o_ready = 0;
    logic [31:0]  i_data = 0;
    logic         i_ack, o_valid, o_last, o_err;
    logic [127:0] o_data;
    logic [3:0]   o_wmask;

    always #5 clk = ~clk;

    nvme_fifo_pack dut (
        .clk(clk), .reset(reset), .i_val(i_val), .i_data(i_data), .i_last(i_last),
        .i_err(i_err), .i_ack(i_ack), .o_valid(o_valid), .o_data(o_data),
        .o_wmask(o_wmask), .o_last(o_last), .o_err(o_err), .o_ready(o_ready)
    );

    typedef struct { logic [31:0] d; logic l; logic e; } word_t;
    typedef struct { logic [127:0] d; logic [3:0] m; logic l; logic e; } beat_t;

    word_t asm_q[$];
    word_t fifo[$];
    beat_t got[$];
    beat_t mo;
    logic  mv = 0;
    int    total = 0, bad = 0, ackcnt = 0, vcnt = 0;
    logic  dut_ack;

    function automatic bit complete();
        return asm_q.size() == 4 || (asm_q.size() > 0 && asm_q[asm_q.size()-1].l);
    endfunction

    function automatic beat_t build();
        beat_t b;
        b = '{d: '0, m: '0, l: 1'b0, e: 1'b0};
        foreach (asm_q[i]) begin
            b.d[i*32 +: 32] = asm_q[i].d;
            b.m[i] = 1'b1;
            b.e = b.e | asm_q[i].e;
        end
        b.l = asm_q[asm_q.size()-1].l;
        return b;
    endfunction

    task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    task automatic step(input logic v, input logic [31:0] d, input logic l, input logic e,
                        input logic r, input logic rs);
        logic exp_ack, free;
        i_val = v; i_data = d; i_last = l; i_err = e; o_ready = r; reset = rs;
        #1;
        exp_ack = v && !complete();
        chk("ack", i_ack, exp_ack);
        dut_ack = i_ack;
        if (i_ack === 1'b1) ackcnt++;
        if (o_valid === 1'b1 && r) got.push_back('{d: o_data, m: o_wmask, l: o_last, e: o_err});
        @(posedge clk);
        if (rs) begin
            asm_q.delete();
            mv = 0;
            mo = '{d: '0, m: '0, l: 1'b0, e: 1'b0};
        end else begin
            free = !mv || r;
            if (exp_ack) asm_q.push_back('{d: d, l: l, e: e});
            if (complete() && free) begin
                mo = build();
                mv = 1;
                asm_q.delete();
            end else if (r) mv = 0;
        end
        @(negedge clk);
        chk("valid", o_valid, mv);
        if (o_valid === 1'b1) vcnt++;
        if (mv || rs) begin
            chk("data", o_data, mo.d);
            chk("wmask", o_wmask, mo.m);
            chk("last", o_last, mo.l);
            chk("err", o_err, mo.e);
        end
    endtask

    task automatic w(input logic [31:0] d, input logic l, input logic e, input logic r);
        step(1'b1, d, l, e, r, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic clr();
        got.delete(); ackcnt = 0; vcnt = 0;
    endtask

    initial begin
        int cyc, n1;
        @(negedge clk);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        // 1: full beat of four words
        clr();
        w(32'h11, 0, 0, 1); w(32'h22, 0, 0, 1); w(32'h33, 0, 0, 1); w(32'h44, 0, 0, 1);
        idle(2);
        chk("t1_beats", got.size(), 1);
        if (got.size() > 0) begin
            chk("t1_data", got[0].d, 128'h00000044_00000033_00000022_00000011);
            chk("t1_mask", got[0].m, 4'b1111);
            chk("t1_last", got[0].l, 1'b0);
        end
        chk("t1_vcnt", vcnt, 1);
        chk("t1_ackcnt", ackcnt, 4);
        // 2: partial beat closed by last, next word starts at slot 0
        clr();
        w(32'hA, 0, 0, 1); w(32'hB, 1, 0, 1); w(32'hC, 1, 0, 1);
        idle(2);
        chk("t2_beats", got.size(), 2);
        if (got.size() == 2) begin
            chk("t2_data0", got[0].d, 128'h0000000b_0000000a);
            chk("t2_mask0", got[0].m, 4'b0011);
            chk("t2_last0", got[0].l, 1'b1);
            chk("t2_data1", got[1].d, 128'hc);
            chk("t2_mask1", got[1].m, 4'b0001);
        end
        // 3: stall with a held beat behind a full output register
        clr();
        for (int i = 1; i <= 8; i++) w(i, 0, 0, 0);
        for (int i = 0; i < 5; i++) w(9, 1, 0, 0);
        w(9, 1, 0, 1); w(9, 1, 0, 1);
        idle(2);
        chk("t3_beats", got.size(), 3);
        if (got.size() == 3) begin
            chk("t3_data0", got[0].d, 128'h00000004_00000003_00000002_00000001);
            chk("t3_data1", got[1].d, 128'h00000008_00000007_00000006_00000005);
            chk("t3_data2", got[2].d, 128'h9);
        end
        chk("t3_ackcnt", ackcnt, 9);
        // 4: error on word 2 only taints its own beat
        clr();
        w(1, 0, 0, 1); w(2, 0, 1, 1); w(3, 0, 0, 1); w(4, 0, 0, 1);
        w(5, 0, 0, 1); w(6, 0, 0, 1); w(7, 0, 0, 1); w(8, 0, 0, 1);
        idle(2);
        chk("t4_beats", got.size(), 2);
        if (got.size() == 2) begin
            chk("t4_err0", got[0].e, 1'b1);
            chk("t4_err1", got[1].e, 1'b0);
        end
        // 5: reset discards a partial beat
        clr();
        w(1, 0, 0, 1); w(2, 0, 0, 1);
        step(0, 0, 0, 0, 1, 1); step(0, 0, 0, 0, 1, 1);
        w(32'hA1, 0, 0, 1); w(32'hA2, 0, 0, 1); w(32'hA3, 0, 0, 1); w(32'hA4, 0, 0, 1);
        idle(2);
        chk("t5_beats", got.size(), 1);
        if (got.size() > 0) chk("t5_data", got[0].d, 128'h000000a4_000000a3_000000a2_000000a1);
        // 6: back-to-back single-word beats
        clr();
        for (int i = 1; i <= 6; i++) w(i, 1, 0, 1);
        idle(2);
        chk("t6_beats", got.size(), 6);
        chk("t6_ackcnt", ackcnt, 6);
        chk("t6_vcnt", vcnt, 6);
        n1 = 0;
        foreach (got[i]) if (got[i].m == 4'b0001) n1++;
        chk("t6_mask1", n1, 6);
        if (got.size() == 6) chk("t6_data5", got[5].d, 128'h6);
        // random traffic
        for (int i = 0; i < 400; i++)
            fifo.push_back('{d: $urandom, l: ($urandom_range(0, 3) == 0), e: ($urandom_range(0, 7) == 0)});
        cyc = 0;
        while (fifo.size() > 0 && cyc < 5000) begin
            step($urandom_range(0, 3) != 0, fifo[0].d, fifo[0].l, fifo[0].e,
                 $urandom_range(0, 9) < 7, $urandom_range(0, 199) == 0);
            if (dut_ack === 1'b1) void'(fifo.pop_front());
            cyc++;
        end
        chk("rand_drain", fifo.size(), 0);
        idle(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
